// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle control sequencer.
// Holds the opcodes, state encoding, alu_op / pc_src / reg_dst codes and instruction classes.
// Only constants and types live here; it contains no logic.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_XORI  = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b100110;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  localparam logic [2:0] CL_ALU_R   = 3'd0;
  localparam logic [2:0] CL_ALU_I   = 3'd1;
  localparam logic [2:0] CL_BR      = 3'd2;
  localparam logic [2:0] CL_LS      = 3'd3;
  localparam logic [2:0] CL_JMP     = 3'd4;
  localparam logic [2:0] CL_HALT    = 3'd5;
  localparam logic [2:0] CL_ILLEGAL = 3'd6;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: maps the opcode to its instruction class, static selects and alu_op.
// Purely combinational, zero latency.
// Unknown opcodes report CL_ILLEGAL with sign-extend and add as harmless defaults.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] cls,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       ext_sel
);

  // opcode table: class plus the selects that hold for the whole instruction
  always_comb begin
    cls       = CL_ILLEGAL;
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b1;
    case (op)
      OP_ADD:   begin cls = CL_ALU_R; alu_op = ALU_ADD; end
      OP_SUB:   begin cls = CL_ALU_R; alu_op = ALU_SUB; end
      OP_AND:   begin cls = CL_ALU_R; alu_op = ALU_AND; end
      OP_SLT:   begin cls = CL_ALU_R; alu_op = ALU_SLT; end
      OP_SLL:   begin cls = CL_ALU_R; alu_op = ALU_SLL; alu_src_a = 1'b1; end
      OP_ADDIU: begin cls = CL_ALU_I; alu_op = ALU_ADD; alu_src_b = 1'b1; end
      OP_SLTI:  begin cls = CL_ALU_I; alu_op = ALU_SLT; alu_src_b = 1'b1; end
      OP_ANDI:  begin cls = CL_ALU_I; alu_op = ALU_AND; alu_src_b = 1'b1; ext_sel = 1'b0; end
      OP_ORI:   begin cls = CL_ALU_I; alu_op = ALU_OR;  alu_src_b = 1'b1; ext_sel = 1'b0; end
      OP_XORI:  begin cls = CL_ALU_I; alu_op = ALU_XOR; alu_src_b = 1'b1; ext_sel = 1'b0; end
      OP_SW, OP_LW:            begin cls = CL_LS; alu_src_b = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLTZ: begin cls = CL_BR; alu_op = ALU_SUB; end
      OP_J, OP_JR, OP_JAL:     cls = CL_JMP;
      OP_HALT:                 cls = CL_HALT;
      default:                 cls = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle sequencer driving the shared-ALU MIPS-subset datapath.
// One state per cycle (2..5 cycles/instr); outputs decode combinationally from state, op, zero, sign.
// Macro MC_CTRL_ILLEGAL_TRAP_EN: unknown opcode traps to HALT with sticky illegal; else 2-cycle NOP.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       nReset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       sign,
  output logic       pc_wre,
  output logic       ir_wre,
  output logic       reg_wre,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       db_data_src,
  output logic       wr_data_src,
  output logic [1:0] reg_dst,
  output logic       ext_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       halted,
  output logic       illegal
);

  state_t     st;
  logic [2:0] cls;
  logic [2:0] d_alu_op;
  logic       d_src_a;
  logic       d_src_b;
  logic       d_ext;
  logic       taken;

  mc_decode u_decode (
    .op        (op),
    .cls       (cls),
    .alu_op    (d_alu_op),
    .alu_src_a (d_src_a),
    .alu_src_b (d_src_b),
    .ext_sel   (d_ext)
  );

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // state walk: each instruction visits only the states its class needs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      st <= S_IF;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (st)
        S_IF: st <= S_ID;
        S_ID: begin
          case (cls)
            CL_JMP:  st <= S_IF;
            CL_HALT: st <= S_HALT;
            CL_BR:   st <= S_EXE_BR;
            CL_LS:   st <= S_EXE_LS;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            CL_ILLEGAL: begin
              st        <= S_HALT;
              illegal_q <= 1'b1;
            end
`else
            CL_ILLEGAL: st <= S_IF;
`endif
            default: st <= S_EXE_AL;
          endcase
        end
        S_EXE_AL: st <= S_WB_AL;
        S_WB_AL:  st <= S_IF;
        S_EXE_BR: st <= S_IF;
        S_EXE_LS: st <= S_MEM;
        S_MEM:    st <= (op == OP_SW) ? S_IF : S_WB_LD;
        S_WB_LD:  st <= S_IF;
        S_HALT:   st <= S_HALT;
        default:  st <= S_IF;
      endcase
    end
  end

  assign state  = st;
  assign halted = (st == S_HALT);

  // per-state enables and selects; everything forced low while reset is asserted
  always_comb begin
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    reg_wre     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    db_data_src = 1'b0;
    wr_data_src = 1'b0;
    reg_dst     = RD_RA;
    ext_sel     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_src      = PC_NEXT;
    alu_op      = ALU_ADD;
    taken       = 1'b0;
    // static selects stay put from ID to the end of the instruction
    if (st != S_IF && st != S_HALT) begin
      alu_src_a = d_src_a;
      alu_src_b = d_src_b;
      ext_sel   = d_ext;
      alu_op    = d_alu_op;
    end
    case (st)
      S_IF: ir_wre = 1'b1;
      S_ID: begin
        if (cls == CL_JMP) begin
          pc_wre = 1'b1;
          pc_src = (op == OP_JR) ? PC_RS : PC_JUMP;
          if (op == OP_JAL) begin
            reg_wre     = 1'b1;
            reg_dst     = RD_RA;
            wr_data_src = 1'b1;
          end
        end
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        if (cls == CL_ILLEGAL) begin
          pc_wre = 1'b1;
          pc_src = PC_NEXT;
        end
`endif
      end
      S_EXE_BR: begin
        alu_op = ALU_SUB;
        pc_wre = 1'b1;
        case (op)
          OP_BEQ:  taken = zero;
          OP_BNE:  taken = !zero;
          default: taken = sign;
        endcase
        pc_src = taken ? PC_BRANCH : PC_NEXT;
      end
      S_EXE_LS: begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b1;
        ext_sel   = 1'b1;
      end
      S_MEM: begin
        if (op == OP_SW) begin
          mem_wr = 1'b1;
          pc_wre = 1'b1;
        end else begin
          mem_rd = 1'b1;
        end
      end
      S_WB_AL: begin
        reg_wre = 1'b1;
        pc_wre  = 1'b1;
        reg_dst = (cls == CL_ALU_R) ? RD_RD : RD_RT;
      end
      S_WB_LD: begin
        reg_wre     = 1'b1;
        db_data_src = 1'b1;
        reg_dst     = RD_RT;
        pc_wre      = 1'b1;
      end
      default: ;
    endcase
    if (!nReset) begin
      pc_wre      = 1'b0;
      ir_wre      = 1'b0;
      reg_wre     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      db_data_src = 1'b0;
      wr_data_src = 1'b0;
      reg_dst     = RD_RA;
      ext_sel     = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      pc_src      = PC_NEXT;
      alu_op      = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed then random instruction stream against a path-based reference model.
// The model lists the states each opcode visits and derives the outputs per state from the opcode rules.
// Extra literal checks pin reset values, cycles per instruction and one pc_wre per instruction.
module tb_mc_control_fsm;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       nReset;
  logic [5:0] op;
  logic       zero;
  logic       sign;
  logic       pc_wre, ir_wre, reg_wre, alu_src_a, alu_src_b, db_data_src, wr_data_src;
  logic [1:0] reg_dst;
  logic       ext_sel, mem_rd, mem_wr;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       halted, illegal;
  logic [22:0] dut_vec;

  mc_control_fsm dut (
    .clk(clk), .nReset(nReset), .op(op), .zero(zero), .sign(sign),
    .pc_wre(pc_wre), .ir_wre(ir_wre), .reg_wre(reg_wre),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .db_data_src(db_data_src), .wr_data_src(wr_data_src),
    .reg_dst(reg_dst), .ext_sel(ext_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .pc_src(pc_src), .alu_op(alu_op), .state(state),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign dut_vec = {pc_wre, ir_wre, reg_wre, alu_src_a, alu_src_b, db_data_src, wr_data_src,
                    reg_dst, ext_sel, mem_rd, mem_wr, pc_src, alu_op, state, halted, illegal};

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] mq[$];       // remaining states of the current instruction
  logic [7:0] plan[$];     // directed entries {mode, opcode}; mode 0/1 fixed zero, 2 random, 3 abort in MEM
  logic [5:0] cur_op;
  logic [5:0] prev_op;
  logic       m_ill;
  int         zmode;
  bit         abort_req;
  bit         have_prev;
  int         cyc_cnt, pcw_cnt, halt_cycles, ninstr;

  logic [5:0] legal_ops[18] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                                6'b010011, 6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001,
                                6'b110100, 6'b110101, 6'b110110, 6'b111000, 6'b111001, 6'b111010};

  function automatic bit is_legal(input logic [5:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return (o == 6'b111111);
  endfunction

  function automatic bit is_rtype(input logic [5:0] o);
    return o inside {6'b000000, 6'b000001, 6'b010000, 6'b100111, 6'b011000};
  endfunction

  function automatic bit is_imm(input logic [5:0] o);
    return o inside {6'b000010, 6'b010001, 6'b010010, 6'b010011, 6'b100110};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] o);
    case (o)
      6'b000001, 6'b110100, 6'b110101, 6'b110110: return 3'b001;
      6'b011000:            return 3'b010;
      6'b010010:            return 3'b011;
      6'b010000, 6'b010001: return 3'b100;
      6'b100110, 6'b100111: return 3'b101;
      6'b010011:            return 3'b110;
      default:              return 3'b000;
    endcase
  endfunction

  // cycles from one IF to the next, straight from the per-class table
  function automatic int cpi(input logic [5:0] o);
    if (o inside {6'b111000, 6'b111001, 6'b111010}) return 2;
    if (o inside {6'b110100, 6'b110101, 6'b110110}) return 3;
    if (o == 6'b110001) return 5;
    if (!is_legal(o)) return 2;
    return 4;
  endfunction

  // expected output vector for model state s of opcode o; last = final state of the instruction
  function automatic logic [22:0] model_out(input logic [3:0] s, input logic [5:0] o, input logic z,
                                            input logic sg, input bit last, input logic ill);
    logic pcw, irw, rw, sa, sb, dds, wds, es, mr, mw, tk;
    logic [1:0] rd, ps;
    logic [2:0] ao;
    {pcw, irw, rw, sa, sb, dds, wds, es, mr, mw, tk} = '0;
    rd = 2'b00; ps = 2'b00; ao = 3'b000;
    irw = (s == S_IF);
    if (s != S_IF && s != S_HALT) begin
      es = !(o inside {6'b010001, 6'b010010, 6'b010011});
      sa = (o == 6'b011000);
      sb = is_imm(o) || o == 6'b110000 || o == 6'b110001;
      ao = alu_of(o);
    end
    if (last && s != S_HALT) begin
      pcw = 1'b1;
      if (o == 6'b111000 || o == 6'b111010) ps = 2'b11;
      else if (o == 6'b111001) ps = 2'b10;
      else if (s == S_EXE_BR) begin
        tk = (o == 6'b110100) ? z : (o == 6'b110101) ? !z : sg;
        ps = tk ? 2'b01 : 2'b00;
      end
    end
    if (s == S_ID && o == 6'b111010) begin rw = 1'b1; rd = 2'b00; wds = 1'b1; end
    if (s == S_WB_AL) begin rw = 1'b1; rd = is_rtype(o) ? 2'b10 : 2'b01; end
    if (s == S_WB_LD) begin rw = 1'b1; rd = 2'b01; dds = 1'b1; end
    mr = (s == S_MEM) && (o == 6'b110001);
    mw = (s == S_MEM) && (o == 6'b110000);
    return {pcw, irw, rw, sa, sb, dds, wds, rd, es, mr, mw, ps, ao, s, (s == S_HALT), ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (op=%b state=%0d t=%0t)", name, act, exp, cur_op, state, $time);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    m_ill = 1'b0;
    have_prev = 1'b0;
    halt_cycles = 0;
  endtask

  task automatic start_instr();
    logic [7:0] e;
    logic [5:0] o;
    int r;
    abort_req = 1'b0;
    zmode = 2;
    if (plan.size() > 0) begin
      e = plan.pop_front();
      o = e[5:0];
      zmode = int'(e[7:6]);
      if (zmode == 3) begin abort_req = 1'b1; zmode = 2; end
    end else begin
      r = $urandom_range(0, 99);
      if (r < 3) o = 6'b111111;
      else if (r < 7) begin
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
      end else o = legal_ops[$urandom_range(0, 17)];
    end
    ninstr++;
    cur_op = o;
    op = o;
    mq = {S_IF, S_ID};
    if (o inside {6'b111000, 6'b111001, 6'b111010}) ;
    else if (o == 6'b111111) mq.push_back(S_HALT);
    else if (o inside {6'b110100, 6'b110101, 6'b110110}) mq.push_back(S_EXE_BR);
    else if (o == 6'b110000) begin mq.push_back(S_EXE_LS); mq.push_back(S_MEM); end
    else if (o == 6'b110001) begin mq.push_back(S_EXE_LS); mq.push_back(S_MEM); mq.push_back(S_WB_LD); end
    else if (!is_legal(o)) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      mq.push_back(S_HALT);
`endif
    end else begin mq.push_back(S_EXE_AL); mq.push_back(S_WB_AL); end
  endtask

  // one clock: starts and ends on a falling edge
  task automatic one_cycle();
    logic [22:0] exp;
    if (mq.size() == 0) start_instr();
    zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    sign = 1'($urandom_range(0, 1));
    #1;
    exp = model_out(mq[0], cur_op, zero, sign, mq.size() == 1, m_ill);
    check("outputs", 32'(dut_vec), 32'(exp));
    if (ir_wre) begin
      if (have_prev) begin
        check("cycles_per_instr", cyc_cnt, cpi(prev_op));
        check("pc_wre_once", pcw_cnt, 1);
      end
      have_prev = 1'b1; prev_op = cur_op; cyc_cnt = 0; pcw_cnt = 0;
    end
    cyc_cnt++;
    pcw_cnt += int'(pc_wre);
    if (mq[0] == S_WB_AL && cur_op == 6'b000000) check("add_wb", {reg_wre, reg_dst}, 3'b110);
    if (mq[0] == S_ID && cur_op == 6'b111010)
      check("jal_id", {pc_wre, reg_wre, reg_dst, wr_data_src, pc_src}, 7'b1_1_00_1_11);
    if (mq[0] == S_MEM && cur_op == 6'b110001) check("lw_mem", {mem_rd, mem_wr, pc_wre}, 3'b100);
    if (mq[0] == S_MEM && cur_op == 6'b110000) check("sw_mem", {mem_rd, mem_wr, reg_wre, pc_wre}, 4'b0101);
    if (mq[0] == S_WB_LD) check("wb_ld", {reg_wre, db_data_src, reg_dst, pc_wre}, 5'b1_1_01_1);
    if (mq[0] == S_EXE_BR && cur_op == 6'b110100) check("beq_pc_src", pc_src, {1'b0, zero});
    if (mq[0] == S_HALT) begin
      check("halt_frozen", {halted, pc_wre, ir_wre, reg_wre, mem_wr}, 5'b10000);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      if (!is_legal(cur_op)) check("illegal_flag", illegal, 1);
`endif
      halt_cycles++;
      if (halt_cycles == 10) begin
        nReset = 1'b0;
        #1 check("halt_reset_zero", 32'(dut_vec), 0);
        @(negedge clk);
        nReset = 1'b1;
        reset_model();
        return;
      end
    end
    if (abort_req && mq[0] == S_MEM) begin
      #2 nReset = 1'b0;
      #1 check("abort_mem_wr_state", {mem_wr, state}, {1'b0, 4'd0});
      check("abort_all_zero", 32'(dut_vec), 0);
      @(negedge clk);
      nReset = 1'b1;
      reset_model();
      return;
    end
    @(posedge clk);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    if (mq[0] == S_ID && !is_legal(cur_op)) m_ill = 1'b1;
`endif
    if (mq[0] != S_HALT) void'(mq.pop_front());
    @(negedge clk);
  endtask

  initial begin
    nReset = 1'b0;
    op = 6'b000000;
    zero = 1'b0;
    sign = 1'b0;
    cur_op = 6'b000000;
    prev_op = 6'b000000;
    abort_req = 1'b0;
    zmode = 2;
    cyc_cnt = 0; pcw_cnt = 0; ninstr = 0;
    reset_model();
    plan = {{2'd2, 6'b000000}, {2'd1, 6'b110100}, {2'd0, 6'b110100}, {2'd2, 6'b110001},
            {2'd2, 6'b110000}, {2'd2, 6'b111010}, {2'd2, 6'b111001}, {2'd1, 6'b110101},
            {2'd2, 6'b110110}, {2'd2, 6'b010010}, {2'd2, 6'b011000}, {2'd3, 6'b110000},
            {2'd2, 6'b100110}, {2'd2, 6'b101010}, {2'd2, 6'b000001}, {2'd2, 6'b111111}};
    repeat (3) begin
      @(negedge clk);
      #1 check("reset_outputs", 32'(dut_vec), 0);
    end
    @(negedge clk);
    nReset = 1'b1;
    for (int c = 0; c < 4000 && (plan.size() > 0 || ninstr < 250); c++) one_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle sequencer for the MIPS-subset datapath: replaces the single-cycle control decoder when the CPU is split into IF/ID/EXE/MEM/WB steps sharing one ALU, register file and memory. It walks each instruction through only the states it needs. It issues per-state write enables (PC, IR, register file, data memory) and mux selects from the current opcode and ALU flags. It sits between the instruction register and the datapath muxes.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `nReset` in 1: asynchronous, active-low reset.
- `op` in 6: opcode from the instruction register; stable from ID until the next IF.
- `zero` in 1: ALU result == 0.
- `sign` in 1: ALU result bit 31.
- `pc_wre` out 1: PC load enable.
- `ir_wre` out 1: instruction register load enable.
- `reg_wre` out 1: register file write enable.
- `alu_src_a` out 1: ALU A source; 0 = rs data, 1 = sa.
- `alu_src_b` out 1: ALU B source; 0 = rt data, 1 = extended immediate.
- `db_data_src` out 1: write-back source; 0 = ALU, 1 = data memory.
- `wr_data_src` out 1: write-back select; 0 = db path, 1 = PC+4 (jal).
- `reg_dst` out 2: destination register; 00 = $31, 01 = rt, 10 = rd.
- `ext_sel` out 1: 0 = zero-extend, 1 = sign-extend.
- `mem_rd` out 1: data memory read.
- `mem_wr` out 1: data memory write.
- `pc_src` out 2: next PC; 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump address.
- `alu_op` out 3: 000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt (signed), 110 xor.
- `state` out 4: current state, for debug and bench use.
- `halted` out 1: high in HALT.
- `illegal` out 1: sticky unknown-opcode flag; only with the macro.

## Operation
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, xori 010011, sll 011000, slti 100110, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
- States: IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT.
- IF → ID: `ir_wre`=1.
- ID:
  - j, jr, jal → IF. Asserts `pc_wre` with `pc_src` 11/10/11.
  - jal additionally asserts `reg_wre`, `reg_dst`=00, `wr_data_src`=1.
  - halt → HALT.
  - beq/bne/bltz → EXE_BR.
  - sw/lw → EXE_LS.
  - All other legal opcodes → EXE_AL.
- EXE_AL → WB_AL.
- WB_AL → IF. Asserts `reg_wre` and `pc_wre` with `pc_src`=00.
  - `reg_dst`=10 for R-type (add, sub, and, slt, sll); 01 for immediates.
- EXE_BR → IF. `alu_op`=sub and `pc_wre`=1.
  - `pc_src`=01 when taken, else 00.
  - Taken condition: beq when `zero`; bne when !`zero`; bltz when `sign` (rt forced to $0 by the datapath).
- EXE_LS → MEM: `alu_op`=add, `alu_src_b`=1, `ext_sel`=1.
- MEM:
  - sw: `mem_wr`=1, `pc_wre`=1 → IF.
  - lw: `mem_rd`=1 → WB_LD.
- WB_LD → IF. Asserts `reg_wre`, `db_data_src`=1, `reg_dst`=01, `pc_wre`.
- HALT: all enables 0. Exits only on reset.
- Static selects hold from ID to the end of the instruction:
  - `ext_sel`=0 for andi/ori/xori; 1 otherwise.
  - `alu_src_a`=1 only for sll.
  - `alu_src_b`=1 for immediates, lw and sw.
- Write and PC enables are asserted only in the states listed above; every other state drives them 0.

## Timing
- State register updates on `clk` rising edge. All outputs decode combinationally from state, `op`, `zero` and `sign`.
- Cycles per instruction: j/jr/jal 2, branch 3, ALU 4, sw 4, lw 5.
- `pc_wre` is exactly one cycle per instruction, in its final state. The PC and the IF of the next instruction follow on the next edge.
- Reset low: state=IF immediately, all outputs 0 including `ir_wre`, `halted` and `illegal`.
- Reset release: IF with `ir_wre`=1 on the first edge.
- Reset mid-instruction aborts it. Writes already committed are not undone.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN`
  - Defined: unknown opcode in ID → HALT with `illegal` set, sticky until reset.
  - Undefined: unknown opcode executes as a 2-cycle NOP (ID → IF, `pc_wre`, `pc_src`=00). `illegal` is tied to 0.

## Structure
- Package `mc_ctrl_pkg`: opcode constants, state encoding (4-bit), `alu_op` codes, `pc_src` and `reg_dst` codes.
- Sub-module `mc_decode`: combinational; maps `op` to instruction class (ALU-R, ALU-I, BR, LS, JMP, HALT, ILLEGAL) plus the static selects and `alu_op`.

## Test plan
- Reset held low with `op`=add, then released → outputs 0 during reset; `state` sequence IF, ID, EXE_AL, WB_AL, IF; `reg_wre`=1 and `reg_dst`=10 in WB_AL only.
- beq with `zero`=1, then with `zero`=0 → 3 cycles each; `pc_src`=01 vs 00 in EXE_BR; `pc_wre` high exactly one cycle.
- lw, then sw → lw: `mem_rd` in MEM, WB_LD with `db_data_src`=1, 5 cycles. sw: `mem_wr` for one cycle, no `reg_wre`, 4 cycles.
- jal → 2 cycles; ID asserts `reg_wre`, `reg_dst`=00, `wr_data_src`=1, `pc_src`=11.
- halt, and `op`=101010 → halt: `halted`=1, PC frozen across 10 cycles. Illegal opcode: HALT with `illegal`=1 if the macro is defined, else 2-cycle NOP.
- `nReset` pulsed low during MEM of sw → `mem_wr` drops asynchronously; `state`=IF.
